// File: rtl/imem_loader.sv
// Instruction-memory program loader: length-prefixed big-endian byte stream -> 32-bit word writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_CHK
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t          r_state, w_next;
    logic [15:0]     r_len;
    logic [31:0]     r_asm;
    logic [1:0]      r_bcnt;
    logic [7:0]      r_csum;
    logic            r_err;
    logic [ADDR_W:0] r_word_count;

    logic            w_xfer;
    logic [15:0]     w_len;
    logic [ADDR_W:0] w_wc_inc;
    logic            w_last;
    logic            w_ovf;

    // Every output is a decode of registered state; byte_ready never sees byte_valid.
    assign o_byte_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                          (r_state == S_DATA)   || (r_state == S_CHK);
    assign o_mem_we     = (r_state == S_WRITE);
    assign o_mem_addr   = 32'({r_word_count, 2'b00});
    assign o_mem_wdata  = r_asm;
    assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done       = (r_state == S_DONE);
    assign o_err        = r_err;
    assign o_cpu_hold   = !((r_state == S_DONE) && !r_err);
    assign o_word_count = r_word_count;

    assign w_xfer   = o_byte_ready && i_byte_valid;
    assign w_len    = {r_len[15:8], i_byte_data};
    assign w_ovf    = {1'b0, w_len} > CAP;
    assign w_wc_inc = r_word_count + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last   = 32'(w_wc_inc) == 32'(r_len);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_next = S_LEN_HI;
            S_LEN_HI:       if (w_xfer) w_next = S_LEN_LO;
            S_LEN_LO: if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_len == 16'd0) w_next = S_CHK;
`else
                if (w_len == 16'd0) w_next = S_DONE;
`endif
                else if (w_ovf)     w_next = S_DONE;
                else                w_next = S_DATA;
            end
            S_DATA:  if (w_xfer && r_bcnt == 2'd3) w_next = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_WRITE: w_next = w_last ? S_CHK : S_DATA;
            S_CHK:   if (w_xfer) w_next = S_DONE;
`else
            S_WRITE: w_next = w_last ? S_DONE : S_DATA;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_len        <= '0;
            r_asm        <= '0;
            r_bcnt       <= '0;
            r_csum       <= '0;
            r_err        <= 1'b0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (i_start) begin
                    r_word_count <= '0;
                    r_err        <= 1'b0;
                    r_csum       <= '0;
                    r_bcnt       <= '0;
                end
                S_LEN_HI: if (w_xfer) r_len[15:8] <= i_byte_data;
                S_LEN_LO: if (w_xfer) begin
                    r_len <= w_len;
                    if (w_ovf) r_err <= 1'b1;
                end
                // 2-bit byte counter wraps to 0 on the 4th byte, ready for the next word
                S_DATA: if (w_xfer) begin
                    r_asm  <= {r_asm[23:0], i_byte_data};
                    r_bcnt <= r_bcnt + 2'd1;
                    r_csum <= r_csum ^ i_byte_data;
                end
                S_WRITE: r_word_count <= w_wc_inc;
                S_CHK: if (w_xfer) r_err <= (i_byte_data != r_csum);
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes a byte stream into the instruction memory of the single-cycle CPU, the writer end of the instruction-fetch path. It accepts a length-prefixed, big-endian byte stream on a valid/ready interface, assembles 32-bit words and drives the memory write port with byte addresses. It holds the CPU (PC and fetch) in reset until a load completes cleanly.

## Interface
- ADDR_W, 10, word-address width of the instruction memory; capacity 2^ADDR_W words
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  load request; sampled only in IDLE or DONE
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  instruction-memory write enable, one cycle per word
- mem_addr  out  32  byte address, word-aligned (word_idx<<2)
- mem_wdata  out  32  assembled word
- cpu_hold  out  1  high = CPU held in reset
- busy  out  1  load in progress
- done  out  1  load finished; level
- err  out  1  load failed; level, valid when done=1
- word_count  out  ADDR_W+1  words written in current/last load

## Operation
- Byte transfer occurs on a cycle with byte_valid && byte_ready. byte_data need not be held after that cycle.
- Stream format: length N (16-bit, MSB first), then 4*N data bytes; each word is MSB first.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE (plus CHK, see Configuration).
- IDLE: byte_ready=0, cpu_hold=1. On start, go to LEN_HI, clear word_count, err and done.
- LEN_HI / LEN_LO: byte_ready=1. Capture N[15:8], then N[7:0].
  - After LEN_LO: N=0 goes to DONE (no writes, err=0).
  - N > 2^ADDR_W goes to DONE with err=1 and no writes.
  - Otherwise go to DATA.
- DATA: byte_ready=1. Shift bytes into a 32-bit assembly register. The 4th byte goes to WRITE.
- WRITE: byte_ready=0, mem_we=1, mem_addr=word_count<<2, mem_wdata=assembled word. On exit, word_count increments. If word_count+1==N, go to DONE; else return to DATA with the byte counter reset.
- DONE: done=1, busy=0, byte_ready=0. cpu_hold=err (0 on success, 1 on error). start re-enters LEN_HI: cpu_hold=1 again, counters cleared, memory not erased.
- start while busy is ignored. byte_valid in IDLE/DONE is ignored (not consumed).
- Rising word_count never wraps: N is bounded by the capacity check.

## Timing
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, err=0, word_count=0. State is IDLE.
- All outputs are registered or decoded from the state register only. No combinational path from byte_valid to byte_ready.
- start seen at edge t gives busy=1 and byte_ready=1 from t+1.
- The 4th data byte accepted at edge t gives mem_we=1 during cycle t+1 (one cycle only). byte_ready returns at t+2.
- Minimum 5 cycles per word; load time ≥ 2 + 5N cycles.
- done and cpu_hold change on the same edge as the transition into DONE.
- Stalls (byte_valid=0) may occur anywhere, including between bytes of one word; the partial word is retained.
- Reset asserted mid-load: immediate return to IDLE, mem_we drops asynchronously, cpu_hold=1. The partially loaded memory is left as is.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE, state CHK with byte_ready=1 accepts one trailing byte.
  - err=1 if that byte ≠ XOR of all 4N data bytes (header excluded).
  - Then DONE. For N=0 the checksum byte is still required and must be 0x00.
- Undefined: no CHK state and no trailing byte. err arises only from the capacity check.

## Test plan
- Reset, then start with stream 00 02 | 20 08 00 05 | AC 08 00 00 (no checksum) -> mem_we pulses twice: addr 0x0 data 0x20080005, addr 0x4 data 0xAC080000. Then done=1, err=0, cpu_hold=0, word_count=2.
- Same stream with byte_valid dropped for 3 cycles between bytes 2 and 3 of word 0 -> identical writes. byte_ready never asserted in WRITE.
- Header 00 00 -> DONE two cycles after start with no mem_we and cpu_hold=0. With ADDR_W=10, header 04 01 -> done=1, err=1, cpu_hold=1, no writes.
- Assert rst low during the third data byte of a 4-word load -> all outputs at reset values, cpu_hold=1. A following start with a 1-word stream writes addr 0x0 correctly.
- With IMEM_LOADER_CHECKSUM_EN defined, stream 00 01 12 34 56 78 then checksum 0x08 -> err=0. Checksum 0x09 -> err=1 and cpu_hold=1.
- start pulsed during DATA -> no effect. start pulsed in DONE -> new load begins at addr 0x0 and cpu_hold rises on the next edge.
